// File: rtl/case_conv_pkg.sv
// +----------------------------------------------------------------------+
// | case_conv_pkg: shared state encoding and ASCII case constants        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package case_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [7:0] LC_LO      = 8'h61;
  localparam logic [7:0] LC_HI      = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

endpackage

`default_nettype wire

// File: rtl/case_conv_core.sv
// +----------------------------------------------------------------------+
// | case_conv_core: combinational ASCII lower-to-upper case converter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module case_conv_core
  import case_conv_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       en_i,
  output logic [7:0] data_o
);

  logic w_is_lower;

  assign w_is_lower = (data_i >= LC_LO) && (data_i <= LC_HI);
  assign data_o     = (en_i && w_is_lower) ? (data_i - CASE_DELTA) : data_i;

endmodule

`default_nettype wire

// File: rtl/case_conv_arbiter.sv
// +----------------------------------------------------------------------+
// | case_conv_arbiter: round-robin, burst-bounded sharing of one case    |
// | converter between two byte streams, registered tagged output         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module case_conv_arbiter
  import case_conv_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [7:0]       s0_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [7:0]       s1_data,
  input  logic [1:0]       conv_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_src,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [3:0] C_BURST = 4'(BURST);

  state_e           state_q;
  logic             last_q;
  logic [3:0]       burst_q;
  logic             m_valid_q;
  logic [7:0]       m_data_q;
  logic             m_src_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic       w_ld;
  logic       w_gnt;
  logic       w_gnt_vld;
  logic       w_xfer;
  logic [7:0] w_conv_in;
  logic [7:0] w_conv_out;
  logic [3:0] w_burst_d;
  state_e     w_state_d;

  assign w_ld = !m_valid_q || m_ready;

  // Grant only ever selects a channel whose valid is high.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_vld = 1'b0;
    case (state_q)
      OWN0: begin
        if (s0_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt     = (burst_q >= C_BURST) && s1_valid;
        end else if (s1_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt     = 1'b1;
        end
      end
      OWN1: begin
        if (s1_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt     = !((burst_q >= C_BURST) && s0_valid);
        end else if (s0_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt     = 1'b0;
        end
      end
      default: begin
        if (s0_valid || s1_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt     = (s0_valid && s1_valid) ? !last_q : s1_valid;
        end
      end
    endcase
  end

  assign w_xfer    = w_ld && w_gnt_vld;
  assign s0_ready  = rst_n && w_xfer && !w_gnt;
  assign s1_ready  = rst_n && w_xfer && w_gnt;

  assign w_conv_in = w_gnt ? s1_data : s0_data;
  assign w_state_d = w_gnt ? OWN1 : OWN0;
  // Staying with the same owner extends the burst; a handoff restarts it at 1.
  assign w_burst_d = (state_q != w_state_d) ? 4'd1 :
                     (burst_q >= C_BURST)   ? C_BURST : burst_q + 4'd1;

  case_conv_core u_core (
    .data_i (w_conv_in),
    .en_i   (conv_en[w_gnt]),
    .data_o (w_conv_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      burst_q   <= 4'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_src_q   <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else if (w_ld) begin
      if (w_xfer) begin
        state_q   <= w_state_d;
        last_q    <= w_gnt;
        burst_q   <= w_burst_d;
        m_valid_q <= 1'b1;
        m_data_q  <= w_conv_out;
        m_src_q   <= w_gnt;
        if (w_gnt) begin
          cnt1_q <= cnt1_q + CNT_W'(1);
        end else begin
          cnt0_q <= cnt0_q + CNT_W'(1);
        end
      end else begin
        state_q   <= IDLE;
        burst_q   <= 4'd0;
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_src   = m_src_q;
  assign cnt0    = cnt0_q;
  assign cnt1    = cnt1_q;

endmodule

`default_nettype wire

// File: tb/tb_case_conv_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_case_conv_arbiter: directed self-checking bench, BURST=4, CNT_W=4 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_case_conv_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s0_valid, s0_ready, s1_valid, s1_ready;
  logic [7:0] s0_data, s1_data;
  logic [1:0] conv_en;
  logic       m_valid, m_ready, m_src;
  logic [7:0] m_data;
  logic [3:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  logic [7:0] edge_in  [4] = '{8'h60, 8'h7B, 8'hE1, 8'h7A};
  logic [7:0] edge_exp [4] = '{8'h60, 8'h7B, 8'hE1, 8'h5A};
  logic       rot_src  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  case_conv_arbiter #(.BURST(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_data  (s0_data),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_data  (s1_data),
    .conv_en  (conv_en),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_src    (m_src),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    s0_valid = 1'b1;
    s0_data  = 8'h00;
    s1_valid = 1'b0;
    s1_data  = 8'h00;
    conv_en  = 2'b00;
    m_ready  = 1'b1;
    step();
    step();
    chk("rst_s0_ready", 8'(s0_ready), 8'd0);
    chk("rst_m_valid",  8'(m_valid),  8'd0);
    chk("rst_m_data",   m_data,       8'h00);
    chk("rst_m_src",    8'(m_src),    8'd0);
    chk("rst_cnt0",     8'(cnt0),     8'd0);
    chk("rst_cnt1",     8'(cnt1),     8'd0);
    s0_valid = 1'b0;
    rst_n    = 1'b1;
    step();

    // Single converted byte on channel 0
    s0_valid = 1'b1;
    s0_data  = 8'h61;
    conv_en  = 2'b01;
    #1;
    chk("single_s0_ready", 8'(s0_ready), 8'd1);
    chk("single_s1_ready", 8'(s1_ready), 8'd0);
    step();
    chk("single_m_valid", 8'(m_valid), 8'd1);
    chk("single_m_data",  m_data,      8'h41);
    chk("single_m_src",   8'(m_src),   8'd0);
    chk("single_cnt0",    8'(cnt0),    8'd1);
    s0_valid = 1'b0;

    // Passthrough and conversion boundaries on channel 1
    s1_valid = 1'b1;
    s1_data  = 8'h7A;
    conv_en  = 2'b00;
    #1;
    chk("pass_s1_ready", 8'(s1_ready), 8'd1);
    step();
    chk("pass_m_data", m_data,    8'h7A);
    chk("pass_m_src",  8'(m_src), 8'd1);
    chk("pass_cnt1",   8'(cnt1),  8'd1);
    conv_en = 2'b10;
    for (int i = 0; i < 4; i++) begin
      s1_data = edge_in[i];
      step();
      chk("edge_m_data", m_data, edge_exp[i]);
    end
    s1_valid = 1'b0;
    step();
    chk("edge_idle_m_valid", 8'(m_valid), 8'd0);
    chk("edge_cnt1",         8'(cnt1),    8'd5);

    // Burst rotation with both channels always valid
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    s0_data  = 8'h30;
    s1_data  = 8'h31;
    conv_en  = 2'b00;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("rot_s0_ready", 8'(s0_ready), 8'(!rot_src[i]));
      chk("rot_s1_ready", 8'(s1_ready), 8'(rot_src[i]));
      step();
      chk("rot_m_src", 8'(m_src), 8'(rot_src[i]));
    end
    chk("rot_cnt0", 8'(cnt0), 8'd7);
    chk("rot_cnt1", 8'(cnt1), 8'd9);

    // Backpressure holds the output and freezes everything
    m_ready = 1'b0;
    s0_data = 8'h32;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_s0_ready", 8'(s0_ready), 8'd0);
      chk("bp_s1_ready", 8'(s1_ready), 8'd0);
      step();
      chk("bp_m_valid", 8'(m_valid), 8'd1);
      chk("bp_m_data",  m_data,      8'h30);
      chk("bp_m_src",   8'(m_src),   8'd0);
      chk("bp_cnt0",    8'(cnt0),    8'd7);
      chk("bp_cnt1",    8'(cnt1),    8'd9);
    end
    m_ready = 1'b1;
    #1;
    chk("bp_rel_s0_ready", 8'(s0_ready), 8'd1);
    step();
    chk("bp_rel_m_data", m_data,    8'h32);
    chk("bp_rel_m_src",  8'(m_src), 8'd0);
    chk("bp_rel_cnt0",   8'(cnt0),  8'd8);
    chk("bp_rel_cnt1",   8'(cnt1),  8'd9);
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    step();
    chk("bp_drain_m_valid", 8'(m_valid), 8'd0);

    // Idle handoff: s0 served last, so a later tie goes to s1
    conv_en  = 2'b01;
    s0_valid = 1'b1;
    s0_data  = 8'h62;
    step();
    chk("idle_b0", m_data, 8'h42);
    s0_data = 8'h63;
    step();
    chk("idle_b1", m_data, 8'h43);
    s0_valid = 1'b0;
    step();
    chk("idle_m_valid", 8'(m_valid), 8'd0);
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    s0_data  = 8'h64;
    s1_data  = 8'h65;
    conv_en  = 2'b11;
    #1;
    chk("tie_s0_ready", 8'(s0_ready), 8'd0);
    chk("tie_s1_ready", 8'(s1_ready), 8'd1);
    step();
    chk("tie_m_src",  8'(m_src), 8'd1);
    chk("tie_m_data", m_data,    8'h45);
    chk("tie_cnt0",   8'(cnt0),  8'd10);
    chk("tie_cnt1",   8'(cnt1),  8'd10);

    // Asynchronous reset with a byte pending
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    chk("mid_pre_m_valid", 8'(m_valid), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_m_valid", 8'(m_valid), 8'd0);
    chk("mid_cnt0",    8'(cnt0),    8'd0);
    chk("mid_cnt1",    8'(cnt1),    8'd0);
    step();
    rst_n = 1'b1;

    // Counter wrap: 17 bytes into a 4-bit counter
    conv_en  = 2'b00;
    s0_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s0_data = 8'(i);
      step();
    end
    s0_valid = 1'b0;
    chk("wrap_cnt0",   8'(cnt0), 8'd1);
    chk("wrap_cnt1",   8'(cnt1), 8'd0);
    chk("wrap_m_data", m_data,   8'h10);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/case_conv_arbiter.md
Name: case_conv_arbiter

Overview:
- Shares one ASCII upper-case conversion datapath between two byte-stream requesters.
- Arbitration is round-robin with a bounded burst length.
- Each requester has its own conversion enable. A disabled channel passes bytes through unchanged.
- Output is a single registered valid/ready stream tagged with the source channel. It sits between two text sources (e.g. UART RX, ROM string reader) and the display/TX sink.

Parameters:
- BURST, 4, max consecutive bytes granted to one channel while the other is waiting (1..15)
- CNT_W, 16, width of the per-channel accepted-byte counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- s0_valid  in  1  channel 0 byte valid
- s0_ready  out  1  channel 0 byte accepted this cycle when high with s0_valid
- s0_data  in  8  channel 0 ASCII byte
- s1_valid  in  1  channel 1 byte valid
- s1_ready  out  1  channel 1 accept
- s1_data  in  8  channel 1 ASCII byte
- conv_en  in  2  bit k=1: convert channel k; 0: pass through
- m_valid  out  1  output byte valid (registered)
- m_ready  in  1  sink accepts output
- m_data  out  8  converted byte (registered)
- m_src  out  1  source channel of m_data (registered)
- cnt0  out  CNT_W  bytes accepted from channel 0
- cnt1  out  CNT_W  bytes accepted from channel 1

Behaviour:
- Reset (async, rst_n=0):
  - m_valid=0, m_data=8'h00, m_src=0, cnt0=cnt1=0.
  - State=IDLE, last=1 (so channel 0 wins first tie), burst_cnt=0.
  - s0_ready and s1_ready are 0 while rst_n=0.
  - A reset asserted mid-operation drops any pending output byte.
- Conversion: bytes 8'h61..8'h7A map to (byte - 8'h20). All other values (including 8'h80..8'hFF) are unchanged. The function is purely combinational.
- Load enable: ld = !m_valid || m_ready. When ld=0, both readys are 0 and state, burst_cnt and counters hold.
- Ready: s_k_ready = ld && grant==k && s_k_valid_any_grant_rule below. Ready may depend combinationally on valid. Valid must never depend on ready.
- FSM states: IDLE, OWN0, OWN1. The current owner is held in state; `last` records the channel most recently served.
  - IDLE:
    - If exactly one channel is valid, grant it.
    - If both are valid, grant !last.
    - On transfer, go to OWNk with burst_cnt=1.
  - OWNk with s_k_valid=1:
    - If burst_cnt<BURST, or the other channel is not valid: grant k; burst_cnt++ (saturating at BURST).
    - If burst_cnt==BURST and the other channel is valid: grant the other channel, go to OWN(other), burst_cnt=1.
  - OWNk with s_k_valid=0:
    - If the other channel is valid: grant it, go to OWN(other), burst_cnt=1.
    - Otherwise go to IDLE.
  - State only advances on a transfer cycle (ld=1 and the granted channel is valid), except the OWNk→IDLE move, which happens whenever ld=1 and neither channel is valid.
- Output register, on transfer from channel k:
  - m_data <= conv_en[k] ? conv(s_k_data) : s_k_data
  - m_src <= k
  - m_valid <= 1
  - conv_en is sampled in the transfer cycle only.
- If ld=1 and there is no transfer: m_valid <= 0 (m_data and m_src hold).
- Latency: exactly 1 cycle from accept to m_valid. Full throughput of 1 byte/cycle while m_ready=1.
- Output stability: while m_valid=1 and m_ready=0, m_data and m_src are stable.
- Counters: cntk increments by 1 on each accepted byte from k and wraps from all-ones to 0.

Decomposition:
- Shared package (case_conv_pkg):
  - State enum (IDLE/OWN0/OWN1)
  - Constants LC_LO=8'h61, LC_HI=8'h7A, CASE_DELTA=8'h20
- Sub-module case_conv_core: combinational, 8-bit in, 1-bit en, 8-bit out. Implements the conversion rule.
- The arbiter FSM, output register and counters stay in case_conv_arbiter.

Test Plan:
- Single byte: reset; s0 sends 8'h61 with conv_en=2'b01, m_ready=1. Required: s0_ready=1 in the same cycle, next cycle m_valid=1, m_data=8'h41, m_src=0, cnt0=1.
- Passthrough and edge values: conv_en=2'b00 on s1 with 8'h7A → 8'h7A. Then with conv_en=2'b10: 8'h60→8'h60, 8'h7B→8'h7B, 8'hE1→8'hE1, 8'h7A→8'h5A.
- Burst rotation: BURST=4, both channels continuously valid, m_ready=1. Required m_src sequence after reset: 0,0,0,0,1,1,1,1,0,... Each readyk is high only in its own window.
- Backpressure: hold m_ready=0 after the first output. Required: m_data and m_src stable, s0_ready=s1_ready=0, counters frozen. Release m_ready and check that no byte is lost or duplicated.
- Idle handoff: s0 sends 2 bytes then drops valid while s1 is idle. Required: FSM returns to IDLE. A later simultaneous request from both channels grants s1 first (last=0).
- Reset mid-stream and counter wrap:
  - Assert rst_n=0 asynchronously with m_valid=1. Required: m_valid=0 immediately and cnt0=cnt1=0.
  - With CNT_W=4, send 17 bytes on s0. Required: cnt0=1.
